// File: rtl/reg_control_if.sv
// Request/response bus between the instruction sequencer (master) and the
// register-file sequencer (slave).
interface reg_control_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [3:0] req_src;
    logic [3:0] req_dst;
    logic [1:0] req_bytes;
    logic       done;
    logic       err;

    modport master (
        output req_valid, req_op, req_src, req_dst, req_bytes,
        input  req_ready, done, err
    );

    modport slave (
        input  req_valid, req_op, req_src, req_dst, req_bytes,
        output req_ready, done, err
    );
endinterface

// File: rtl/reg_control.sv
// Register-file access sequencer: maps logical register codes onto physical
// pairs through the Z80 bank-swap state and times selects/oe/bus switch #4.
module reg_control (
    input  logic          clk,
    input  logic          nreset,
    reg_control_if.slave  req,
    output logic          reg_sel_af,
    output logic          reg_sel_af2,
    output logic          reg_sel_bc,
    output logic          reg_sel_bc2,
    output logic          reg_sel_de,
    output logic          reg_sel_de2,
    output logic          reg_sel_hl,
    output logic          reg_sel_hl2,
    output logic          reg_sel_ix,
    output logic          reg_sel_iy,
    output logic          reg_sel_wz,
    output logic          reg_sel_sp,
    output logic          reg_sel_gp_hi,
    output logic          reg_sel_gp_lo,
    output logic          reg_gp_oe,
    output logic          reg_sel_pc,
    output logic          reg_sel_ir,
    output logic          reg_sel_sys_hi,
    output logic          reg_sel_sys_lo,
    output logic          reg_sys_oe,
    output logic          ctl_sw_4u,
    output logic          ctl_sw_4d,
    output logic          bank_af,
    output logic          bank_exx
);

    localparam int unsigned NUM_PHYS = 14;
    localparam int unsigned NUM_GP   = 12;

    // One-hot physical select positions; GP pairs occupy the low NUM_GP bits
    localparam logic [NUM_PHYS-1:0] OH_AF  = NUM_PHYS'(1) << 0;
    localparam logic [NUM_PHYS-1:0] OH_AF2 = NUM_PHYS'(1) << 1;
    localparam logic [NUM_PHYS-1:0] OH_BC  = NUM_PHYS'(1) << 2;
    localparam logic [NUM_PHYS-1:0] OH_BC2 = NUM_PHYS'(1) << 3;
    localparam logic [NUM_PHYS-1:0] OH_DE  = NUM_PHYS'(1) << 4;
    localparam logic [NUM_PHYS-1:0] OH_DE2 = NUM_PHYS'(1) << 5;
    localparam logic [NUM_PHYS-1:0] OH_HL  = NUM_PHYS'(1) << 6;
    localparam logic [NUM_PHYS-1:0] OH_HL2 = NUM_PHYS'(1) << 7;
    localparam logic [NUM_PHYS-1:0] OH_IX  = NUM_PHYS'(1) << 8;
    localparam logic [NUM_PHYS-1:0] OH_IY  = NUM_PHYS'(1) << 9;
    localparam logic [NUM_PHYS-1:0] OH_WZ  = NUM_PHYS'(1) << 10;
    localparam logic [NUM_PHYS-1:0] OH_SP  = NUM_PHYS'(1) << 11;
    localparam logic [NUM_PHYS-1:0] OH_PC  = NUM_PHYS'(1) << 12;
    localparam logic [NUM_PHYS-1:0] OH_IR  = NUM_PHYS'(1) << 13;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_READ    = 3'd1;
    localparam logic [2:0] OP_WRITE   = 3'd2;
    localparam logic [2:0] OP_XFER    = 3'd3;
    localparam logic [2:0] OP_EX_AF   = 3'd4;
    localparam logic [2:0] OP_EXX     = 3'd5;
    localparam logic [2:0] OP_EX_DEHL = 3'd6;
    localparam logic [2:0] OP_RSVD    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEL   = 2'd1,
        ST_DRIVE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    logic [NUM_PHYS-1:0] sel_q, sel_d;
    logic                gp_hi_q, gp_hi_d, gp_lo_q, gp_lo_d;
    logic                sys_hi_q, sys_hi_d, sys_lo_q, sys_lo_d;
    logic                gp_oe_q, gp_oe_d, sys_oe_q, sys_oe_d;
    logic                sw_4u_q, sw_4u_d, sw_4d_q, sw_4d_d;
    logic                done_q, done_d, err_q, err_d;
    logic                bank_af_q, bank_af_d, bank_exx_q, bank_exx_d;
    logic                dehl0_q, dehl0_d, dehl1_q, dehl1_d;
    logic [2:0]          op_q, op_d;
    logic                rej_q, rej_d;
    logic                src_sys_q, src_sys_d;

    logic [NUM_PHYS-1:0] src_oh_c, dst_oh_c, acc_mask_c;
    logic                acc_rej_c, acc_src_sys_c, acc_dst_sys_c;

    // Logical code -> one-hot physical pair under the current bank state
    function automatic logic [NUM_PHYS-1:0] map_code(
        input logic [3:0] code,
        input logic       b_af,
        input logic       b_exx,
        input logic       swap0,
        input logic       swap1
    );
        logic                swap;
        logic [NUM_PHYS-1:0] de_oh;
        logic [NUM_PHYS-1:0] hl_oh;
        swap  = b_exx ? swap1 : swap0;
        de_oh = b_exx ? OH_DE2 : OH_DE;
        hl_oh = b_exx ? OH_HL2 : OH_HL;
        case (code)
            4'd0:    map_code = b_exx ? OH_BC2 : OH_BC;
            4'd1:    map_code = swap ? hl_oh : de_oh;
            4'd2:    map_code = swap ? de_oh : hl_oh;
            4'd3:    map_code = b_af ? OH_AF2 : OH_AF;
            4'd4:    map_code = OH_IX;
            4'd5:    map_code = OH_IY;
            4'd6:    map_code = OH_WZ;
            4'd7:    map_code = OH_SP;
            4'd8:    map_code = OH_PC;
            4'd9:    map_code = OH_IR;
            default: map_code = '0;
        endcase
    endfunction

    // Request decode and validity, evaluated against the live inputs
    always_comb begin
        src_oh_c      = map_code(req.req_src, bank_af_q, bank_exx_q, dehl0_q, dehl1_q);
        dst_oh_c      = map_code(req.req_dst, bank_af_q, bank_exx_q, dehl0_q, dehl1_q);
        acc_src_sys_c = |src_oh_c[NUM_PHYS-1:NUM_GP];
        acc_dst_sys_c = |dst_oh_c[NUM_PHYS-1:NUM_GP];
        acc_rej_c     = 1'b0;
        acc_mask_c    = '0;
        case (req.req_op)
            OP_READ, OP_WRITE: begin
                acc_rej_c  = (src_oh_c == '0) || (req.req_bytes == 2'b00);
                acc_mask_c = src_oh_c;
            end
            OP_XFER: begin
                acc_rej_c  = (src_oh_c == '0) || (dst_oh_c == '0) ||
                             (req.req_bytes == 2'b00) || (acc_src_sys_c == acc_dst_sys_c);
                acc_mask_c = src_oh_c | dst_oh_c;
            end
            OP_RSVD: acc_rej_c = 1'b1;
            default: acc_rej_c = 1'b0;
        endcase
        if (acc_rej_c) begin
            acc_mask_c = '0;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d    = state_q;
        sel_d      = '0;
        gp_hi_d    = 1'b0;
        gp_lo_d    = 1'b0;
        sys_hi_d   = 1'b0;
        sys_lo_d   = 1'b0;
        gp_oe_d    = 1'b0;
        sys_oe_d   = 1'b0;
        sw_4u_d    = 1'b0;
        sw_4d_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        bank_af_d  = bank_af_q;
        bank_exx_d = bank_exx_q;
        dehl0_d    = dehl0_q;
        dehl1_d    = dehl1_q;
        op_d       = op_q;
        rej_d      = rej_q;
        src_sys_d  = src_sys_q;

        case (state_q)
            ST_IDLE: begin
                if (req.req_valid && ready_q) begin
                    state_d   = ST_SEL;
                    op_d      = req.req_op;
                    rej_d     = acc_rej_c;
                    src_sys_d = acc_src_sys_c;
                    sel_d     = acc_mask_c;
                    gp_hi_d   = req.req_bytes[1] & (|acc_mask_c[NUM_GP-1:0]);
                    gp_lo_d   = req.req_bytes[0] & (|acc_mask_c[NUM_GP-1:0]);
                    sys_hi_d  = req.req_bytes[1] & (|acc_mask_c[NUM_PHYS-1:NUM_GP]);
                    sys_lo_d  = req.req_bytes[0] & (|acc_mask_c[NUM_PHYS-1:NUM_GP]);
                    err_d     = acc_rej_c;
                    done_d    = !acc_rej_c && (req.req_op != OP_READ) && (req.req_op != OP_XFER);
                end
            end
            ST_SEL: begin
                state_d = ST_IDLE;
                if (!rej_q) begin
                    case (op_q)
                        OP_EX_AF: bank_af_d  = ~bank_af_q;
                        OP_EXX:   bank_exx_d = ~bank_exx_q;
                        OP_EX_DEHL: begin
                            if (bank_exx_q) dehl1_d = ~dehl1_q;
                            else            dehl0_d = ~dehl0_q;
                        end
                        OP_READ, OP_XFER: begin
                            // Selects already stable for a cycle, so oe/switch may now rise
                            state_d  = ST_DRIVE;
                            sel_d    = sel_q;
                            gp_hi_d  = gp_hi_q;
                            gp_lo_d  = gp_lo_q;
                            sys_hi_d = sys_hi_q;
                            sys_lo_d = sys_lo_q;
                            gp_oe_d  = !src_sys_q;
                            sys_oe_d = src_sys_q;
                            sw_4u_d  = (op_q == OP_XFER) && !src_sys_q;
                            sw_4d_d  = (op_q == OP_XFER) && src_sys_q;
                            done_d   = 1'b1;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_DRIVE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b1;
            sel_q      <= '0;
            gp_hi_q    <= 1'b0;
            gp_lo_q    <= 1'b0;
            sys_hi_q   <= 1'b0;
            sys_lo_q   <= 1'b0;
            gp_oe_q    <= 1'b0;
            sys_oe_q   <= 1'b0;
            sw_4u_q    <= 1'b0;
            sw_4d_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            bank_af_q  <= 1'b0;
            bank_exx_q <= 1'b0;
            dehl0_q    <= 1'b0;
            dehl1_q    <= 1'b0;
            op_q       <= OP_NOP;
            rej_q      <= 1'b0;
            src_sys_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            sel_q      <= sel_d;
            gp_hi_q    <= gp_hi_d;
            gp_lo_q    <= gp_lo_d;
            sys_hi_q   <= sys_hi_d;
            sys_lo_q   <= sys_lo_d;
            gp_oe_q    <= gp_oe_d;
            sys_oe_q   <= sys_oe_d;
            sw_4u_q    <= sw_4u_d;
            sw_4d_q    <= sw_4d_d;
            done_q     <= done_d;
            err_q      <= err_d;
            bank_af_q  <= bank_af_d;
            bank_exx_q <= bank_exx_d;
            dehl0_q    <= dehl0_d;
            dehl1_q    <= dehl1_d;
            op_q       <= op_d;
            rej_q      <= rej_d;
            src_sys_q  <= src_sys_d;
        end
    end

    assign req.req_ready    = ready_q;
    assign req.done         = done_q;
    assign req.err          = err_q;
    assign reg_sel_af       = sel_q[0];
    assign reg_sel_af2      = sel_q[1];
    assign reg_sel_bc       = sel_q[2];
    assign reg_sel_bc2      = sel_q[3];
    assign reg_sel_de       = sel_q[4];
    assign reg_sel_de2      = sel_q[5];
    assign reg_sel_hl       = sel_q[6];
    assign reg_sel_hl2      = sel_q[7];
    assign reg_sel_ix       = sel_q[8];
    assign reg_sel_iy       = sel_q[9];
    assign reg_sel_wz       = sel_q[10];
    assign reg_sel_sp       = sel_q[11];
    assign reg_sel_pc       = sel_q[12];
    assign reg_sel_ir       = sel_q[13];
    assign reg_sel_gp_hi    = gp_hi_q;
    assign reg_sel_gp_lo    = gp_lo_q;
    assign reg_sel_sys_hi   = sys_hi_q;
    assign reg_sel_sys_lo   = sys_lo_q;
    assign reg_gp_oe        = gp_oe_q;
    assign reg_sys_oe       = sys_oe_q;
    assign ctl_sw_4u        = sw_4u_q;
    assign ctl_sw_4d        = sw_4d_q;
    assign bank_af          = bank_af_q;
    assign bank_exx         = bank_exx_q;

endmodule

// File: tb/tb_reg_control.sv
// Scoreboard bench for reg_control: a bank-state reference model predicts each
// response; a negedge monitor pops and compares whenever done or err appears.
module tb_reg_control;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    reg_control_if bus();

    logic reg_sel_af, reg_sel_af2, reg_sel_bc, reg_sel_bc2, reg_sel_de, reg_sel_de2;
    logic reg_sel_hl, reg_sel_hl2, reg_sel_ix, reg_sel_iy, reg_sel_wz, reg_sel_sp;
    logic reg_sel_gp_hi, reg_sel_gp_lo, reg_gp_oe;
    logic reg_sel_pc, reg_sel_ir, reg_sel_sys_hi, reg_sel_sys_lo, reg_sys_oe;
    logic ctl_sw_4u, ctl_sw_4d, bank_af, bank_exx;

    reg_control dut (
        .clk(clk), .nreset(nreset), .req(bus),
        .reg_sel_af(reg_sel_af), .reg_sel_af2(reg_sel_af2),
        .reg_sel_bc(reg_sel_bc), .reg_sel_bc2(reg_sel_bc2),
        .reg_sel_de(reg_sel_de), .reg_sel_de2(reg_sel_de2),
        .reg_sel_hl(reg_sel_hl), .reg_sel_hl2(reg_sel_hl2),
        .reg_sel_ix(reg_sel_ix), .reg_sel_iy(reg_sel_iy),
        .reg_sel_wz(reg_sel_wz), .reg_sel_sp(reg_sel_sp),
        .reg_sel_gp_hi(reg_sel_gp_hi), .reg_sel_gp_lo(reg_sel_gp_lo), .reg_gp_oe(reg_gp_oe),
        .reg_sel_pc(reg_sel_pc), .reg_sel_ir(reg_sel_ir),
        .reg_sel_sys_hi(reg_sel_sys_hi), .reg_sel_sys_lo(reg_sel_sys_lo), .reg_sys_oe(reg_sys_oe),
        .ctl_sw_4u(ctl_sw_4u), .ctl_sw_4d(ctl_sw_4d),
        .bank_af(bank_af), .bank_exx(bank_exx)
    );

    logic [13:0] sel_vec;
    logic [3:0]  b_vec, oe_vec;
    assign sel_vec = {reg_sel_ir, reg_sel_pc, reg_sel_sp, reg_sel_wz, reg_sel_iy, reg_sel_ix,
                      reg_sel_hl2, reg_sel_hl, reg_sel_de2, reg_sel_de, reg_sel_bc2, reg_sel_bc,
                      reg_sel_af2, reg_sel_af};
    assign b_vec   = {reg_sel_gp_hi, reg_sel_gp_lo, reg_sel_sys_hi, reg_sel_sys_lo};
    assign oe_vec  = {reg_gp_oe, reg_sys_oe, ctl_sw_4u, ctl_sw_4d};

    typedef struct {
        bit          err;
        bit          two;
        logic [13:0] sel;
        logic [3:0]  bsel;
        logic [3:0]  oe;
        bit          baf;
        bit          bexx;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   m_af = 0, m_exx = 0, m_d0 = 0, m_d1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference mapping: physical index 0..13 (af,af2,bc,bc2,de,de2,hl,hl2,ix,iy,wz,sp,pc,ir) or -1
    function automatic int phys(input logic [3:0] c);
        bit sw;
        sw = m_exx ? m_d1 : m_d0;
        case (c)
            4'd0: return m_exx ? 3 : 2;
            4'd1: return m_exx ? (sw ? 7 : 5) : (sw ? 6 : 4);
            4'd2: return m_exx ? (sw ? 5 : 7) : (sw ? 4 : 6);
            4'd3: return m_af ? 1 : 0;
            4'd4: return 8;
            4'd5: return 9;
            4'd6: return 10;
            4'd7: return 11;
            4'd8: return 12;
            4'd9: return 13;
            default: return -1;
        endcase
    endfunction

    task automatic push_exp(input logic [2:0] op, input logic [3:0] src, input logic [3:0] dst,
                            input logic [1:0] bytes, input int acc_cyc);
        exp_t e;
        int ps, pd;
        bit gp, sys;
        ps = phys(src);
        pd = phys(dst);
        e.err = 0; e.sel = '0; e.oe = '0;
        e.baf = m_af; e.bexx = m_exx;
        case (op)
            3'd1, 3'd2: begin
                e.err = (ps < 0) || (bytes == 2'b00);
                if (!e.err) e.sel = 14'(1) << ps;
                if (!e.err) e.oe = (ps >= 12) ? 4'b0100 : 4'b1000;
            end
            3'd3: begin
                e.err = (ps < 0) || (pd < 0) || (bytes == 2'b00) || ((ps >= 12) == (pd >= 12));
                if (!e.err) e.sel = (14'(1) << ps) | (14'(1) << pd);
                if (!e.err) e.oe = (ps >= 12) ? 4'b0101 : 4'b1010;
            end
            3'd7: e.err = 1;
            default: e.err = 0;
        endcase
        gp  = |e.sel[11:0];
        sys = |e.sel[13:12];
        e.bsel = {bytes[1] & gp, bytes[0] & gp, bytes[1] & sys, bytes[0] & sys};
        e.two  = !e.err && (op == 3'd1 || op == 3'd3);
        e.cyc  = acc_cyc + (e.two ? 1 : 0);
        exp_q.push_back(e);
        if (!e.err) begin
            if (op == 3'd4) m_af = ~m_af;
            if (op == 3'd5) m_exx = ~m_exx;
            if (op == 3'd6) begin
                if (m_exx) m_d1 = ~m_d1;
                else       m_d0 = ~m_d0;
            end
        end
    endtask

    // Called at a negedge; returns at a negedge with the DUT idle again
    task automatic issue(input logic [2:0] op, input logic [3:0] src, input logic [3:0] dst,
                         input logic [1:0] bytes);
        int w;
        bus.req_valid = 1'b1;
        bus.req_op = op; bus.req_src = src; bus.req_dst = dst; bus.req_bytes = bytes;
        w = 0;
        while (bus.req_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) begin
            check("accept_timeout", 64'(w), 64'(0));
            bus.req_valid = 1'b0;
            return;
        end
        push_exp(op, src, dst, bytes, cyc + 1);
        @(negedge clk);
        w = 0;
        while (bus.req_ready !== 1'b1 && w < 20) begin
            bus.req_op = 3'($urandom); bus.req_src = 4'($urandom);
            bus.req_dst = 4'($urandom); bus.req_bytes = 2'($urandom);
            @(negedge clk);
            w++;
        end
        if (w >= 20) check("busy_timeout", 64'(w), 64'(0));
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        #1 check("drain", 64'(exp_q.size()), 64'(0));
    endtask

    logic [13:0] prev_sel = '0;
    logic [3:0]  prev_b = '0, prev_oe = '0;
    logic [1:0]  prev_de = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!nreset) begin
            prev_sel = '0; prev_b = '0; prev_oe = '0; prev_de = '0;
        end else begin
            check("excl_oe_sw", 64'({reg_gp_oe & reg_sys_oe, ctl_sw_4u & ctl_sw_4d}), 64'(0));
            if (bus.req_ready)
                check("idle_quiet", 64'({sel_vec, b_vec, oe_vec, bus.done, bus.err}), 64'(0));
            if (bus.done || bus.err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 64'({bus.done, bus.err}), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("resp_kind", 64'({bus.done, bus.err}), 64'({!e.err, e.err}));
                    check("resp_cycle", 64'(cyc), 64'(e.cyc));
                    check("resp_sel", 64'(sel_vec), 64'(e.sel));
                    check("resp_bytesel", 64'(b_vec), 64'(e.bsel));
                    check("resp_oe_sw", 64'(oe_vec), 64'(e.two ? e.oe : 4'b0000));
                    check("resp_bank", 64'({bank_af, bank_exx}), 64'({e.baf, e.bexx}));
                    if (e.two) begin
                        check("sel_phase_sel", 64'(prev_sel), 64'(e.sel));
                        check("sel_phase_bytesel", 64'(prev_b), 64'(e.bsel));
                        check("sel_phase_no_oe", 64'({prev_oe, prev_de}), 64'(0));
                    end
                end
            end
            prev_sel = sel_vec; prev_b = b_vec; prev_oe = oe_vec; prev_de = {bus.done, bus.err};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        logic [2:0] op;
        logic [3:0] s, d;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_src = '0;
        bus.req_dst = '0; bus.req_bytes = '0;
        repeat (2) @(negedge clk);
        check("rst_outputs", 64'({sel_vec, b_vec, oe_vec, bus.done, bus.err}), 64'(0));
        check("rst_ready", 64'(bus.req_ready), 64'(1));
        check("rst_bank", 64'({bank_af, bank_exx}), 64'(0));
        nreset = 1'b1;
        @(negedge clk);

        issue(3'd2, 4'd3, 4'd0, 2'b11);   // WRITE AF
        issue(3'd4, 4'd0, 4'd0, 2'b00);   // EX AF,AF'
        issue(3'd1, 4'd3, 4'd0, 2'b01);   // READ AF -> af2
        issue(3'd6, 4'd0, 4'd0, 2'b00);   // EX DE,HL bank 0
        issue(3'd1, 4'd1, 4'd0, 2'b11);   // READ DE -> hl
        issue(3'd5, 4'd0, 4'd0, 2'b00);   // EXX
        issue(3'd1, 4'd1, 4'd0, 2'b11);   // READ DE -> de2
        issue(3'd3, 4'd6, 4'd8, 2'b11);   // XFER WZ -> PC
        issue(3'd3, 4'd9, 4'd7, 2'b10);   // XFER IR -> SP
        issue(3'd3, 4'd0, 4'd1, 2'b11);   // reject: same domain
        issue(3'd1, 4'd12, 4'd0, 2'b11);  // reject: invalid code
        issue(3'd2, 4'd3, 4'd0, 2'b00);   // reject: no bytes
        issue(3'd7, 4'd0, 4'd0, 2'b11);   // reject: reserved op
        issue(3'd0, 4'd0, 4'd0, 2'b00);   // NOP
        drain();

        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom_range(0, 7));
            s  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            d  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            issue(op, s, d, 2'($urandom));
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
        end
        drain();

        // Reset in the DRIVE cycle of a READ with busy-time input churn
        issue(3'd4, 4'd0, 4'd0, 2'b00);
        drain();
        bus.req_valid = 1'b1; bus.req_op = 3'd1; bus.req_src = 4'd2; bus.req_bytes = 2'b11;
        @(negedge clk);
        bus.req_op = 3'd2; bus.req_src = 4'd5; bus.req_bytes = 2'b01;
        @(posedge clk);
        #1 nreset = 1'b0;
        m_af = 0; m_exx = 0; m_d0 = 0; m_d1 = 0;
        #1 check("mid_rst_outputs", 64'({sel_vec, b_vec, oe_vec, bus.done, bus.err}), 64'(0));
        check("mid_rst_bank", 64'({bank_af, bank_exx}), 64'(0));
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(bus.req_ready), 64'(1));
        repeat (4) @(negedge clk);
        issue(3'd2, 4'd3, 4'd0, 2'b11);   // AF back to bank 0
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
